ucode_sequencer: RTL and testbench
==================================

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 SHALL have parameter UADDR_W, default 5: micro-address width; the control store holds 2**UADDR_W words.
REQ-002 SHALL have parameter CW_W, default 30: control-word width; CW_W >= UADDR_W+3.
REQ-003 SHALL have parameter STACK_DEPTH, default 4: number of micro-call return entries.
REQ-004 SHALL have parameter RESET_ADDR, default 0: micro-address loaded on reset.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port op, input, 2: instruction Op field used for dispatch.
REQ-008 SHALL have port funct, input, 6: instruction Funct field used for dispatch.
REQ-009 SHALL have port cond_true, input, 1: condition-check result for conditional micro-branches.
REQ-010 SHALL have port stall, input, 1: holds all sequencer state.
REQ-011 SHALL have ports wcs_we (input, 1), wcs_addr (input, UADDR_W) and wcs_data (input, CW_W): control-store write port.
REQ-012 SHALL have port cw, output, CW_W: control word at the current micro-address.
REQ-013 SHALL have port upc, output, UADDR_W: current micro-address.
REQ-014 SHALL have ports stack_ovf (output, 1) and stack_unf (output, 1): sticky micro-stack error flags.

Function
REQ-015 SHALL implement the control store as 2**UADDR_W x CW_W storage, written synchronously when wcs_we=1 and read combinationally: cw = store[upc].
REQ-016 SHALL decode control-word fields as NA = cw[UADDR_W-1:0] and SEQ = cw[UADDR_W+2:UADDR_W]; bits above these pass to the datapath unchanged.
REQ-017 SHALL update upc every cycle in which reset=1 and stall=0, according to SEQ.
REQ-018 SEQ=000 (JUMP) SHALL set next upc to NA.
REQ-019 SEQ=001 (INC) SHALL set next upc to upc+1 modulo 2**UADDR_W; from all-ones it wraps to 0.
REQ-020 SEQ=010 (DISPATCH1) SHALL set next upc to NA + {op, funct[5]}, a 3-bit zero-extended offset added modulo 2**UADDR_W.
REQ-021 SEQ=011 (DISPATCH2) SHALL set next upc to NA + funct[0], added modulo 2**UADDR_W.
REQ-022 SEQ=100 (CBR) SHALL set next upc to NA if cond_true=1, otherwise to upc+1.
REQ-023 SEQ=101 (CALL) SHALL push upc+1 onto the stack and set next upc to NA.
REQ-024 SEQ=110 (RET) SHALL pop the stack top into next upc.
REQ-025 SEQ=111 (HOLD) SHALL leave upc unchanged.
REQ-026 Micro-stack: SHALL be LIFO; depth counter range 0..STACK_DEPTH.
REQ-027 A CALL with the stack full SHALL drop the push, set stack_ovf, and still jump to NA.
REQ-028 A RET with the stack empty SHALL set stack_unf and load RESET_ADDR into upc.
REQ-029 When stall=1, SHALL hold upc, the stack and the depth counter; a control-store write SHALL still complete.
REQ-030 A write to the address equal to upc SHALL appear on cw in the cycle after the edge; there is no bypass within the same cycle.
REQ-031 stack_ovf and stack_unf SHALL remain set until reset.

Reset
REQ-032 On a rising clk edge with reset=0, SHALL set upc=RESET_ADDR, depth=0, stack_ovf=0 and stack_unf=0.
REQ-033 Reset SHALL take priority over stall and SEQ.
REQ-034 Reset SHALL NOT clear the control store; a wcs write in the same cycle as reset SHALL complete.
REQ-035 Reset asserted mid-CALL or mid-RET SHALL discard the operation.

Configuration
REQ-036 Macro UCODE_STACK_EN defined: CALL and RET SHALL behave per REQ-023 to REQ-028.
REQ-037 Macro UCODE_STACK_EN undefined: no stack storage SHALL be built, CALL SHALL behave as JUMP, RET SHALL behave as INC, and stack_ovf and stack_unf SHALL be tied to 0.

Verification
REQ-038 Load store[0] with SEQ=001, release reset -> upc goes 0,1 on successive edges; cw equals the loaded word.
REQ-039 DISPATCH1 with NA=8, op=10, funct[5]=1 -> next upc=13; DISPATCH2 with NA=3, funct[0]=1 -> next upc=4.
REQ-040 CBR with NA=20 at upc=5 -> cond_true=1 gives upc=20; cond_true=0 gives upc=6.
REQ-041 STACK_DEPTH=4, five nested CALLs from upc=1,2,3,4,5 -> stack_ovf=1 after the fifth; four RETs return to 5,4,3,2; a fifth RET gives upc=RESET_ADDR and stack_unf=1.
REQ-042 stall=1 for 3 cycles during an INC at upc=7 -> upc stays 7, then advances to 8; reset=0 mid-stall -> upc=RESET_ADDR and both flags 0.
REQ-043 INC at upc=31 with UADDR_W=5 -> upc=0; with UCODE_STACK_EN undefined, CALL NA=9 -> upc=9 and stack_ovf stays 0.

Source files
------------

// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: writable control store, next-address selection and a micro-call stack.
// The stack is built only when UCODE_STACK_EN is defined; otherwise CALL acts as JUMP and RET as INC.
module ucode_sequencer #(
  parameter int UADDR_W     = 5,
  parameter int CW_W        = 30,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic               cond_true,
  input  logic               stall,
  input  logic               wcs_we,
  input  logic [UADDR_W-1:0] wcs_addr,
  input  logic [CW_W-1:0]    wcs_data,
  output logic [CW_W-1:0]    cw,
  output logic [UADDR_W-1:0] upc,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int StoreWords = 2 ** UADDR_W;

  typedef enum logic [2:0] {
    SEQ_JUMP  = 3'b000,
    SEQ_INC   = 3'b001,
    SEQ_DISP1 = 3'b010,
    SEQ_DISP2 = 3'b011,
    SEQ_CBR   = 3'b100,
    SEQ_CALL  = 3'b101,
    SEQ_RET   = 3'b110,
    SEQ_HOLD  = 3'b111
  } seq_e;

  logic [CW_W-1:0]    store_q [StoreWords];
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [UADDR_W-1:0] na, upc_inc, disp1_off, disp2_off;
  seq_e               seq;

  // Control-store writes are independent of reset and stall.
  always_ff @(posedge clk) begin
    if (wcs_we) store_q[wcs_addr] <= wcs_data;
  end

  assign cw        = store_q[upc_q];
  assign upc       = upc_q;
  assign na        = cw[UADDR_W-1:0];
  assign seq       = seq_e'(cw[UADDR_W+2:UADDR_W]);
  assign upc_inc   = upc_q + 1'b1;
  assign disp1_off = UADDR_W'({op, funct[5]});
  assign disp2_off = UADDR_W'(funct[0]);

  logic unused_funct;
  assign unused_funct = ^funct[4:1];

`ifdef UCODE_STACK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [UADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [DW-1:0]      depth_q, depth_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    upc_d   = upc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!stall) begin
      case (seq)
        SEQ_JUMP:  upc_d = na;
        SEQ_INC:   upc_d = upc_inc;
        SEQ_DISP1: upc_d = na + disp1_off;
        SEQ_DISP2: upc_d = na + disp2_off;
        SEQ_CBR:   upc_d = cond_true ? na : upc_inc;
        SEQ_CALL: begin
          upc_d = na;
          if (depth_q < DW'(STACK_DEPTH)) begin
            stack_d[SW'(depth_q)] = upc_inc;
            depth_d               = depth_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        SEQ_RET: begin
          if (depth_q == '0) begin
            upc_d = UADDR_W'(RESET_ADDR);
            unf_d = 1'b1;
          end else begin
            upc_d   = stack_q[SW'(depth_q - 1'b1)];
            depth_d = depth_q - 1'b1;
          end
        end
        SEQ_HOLD:  upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upc_q   <= UADDR_W'(RESET_ADDR);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries above depth are don't-care, so the stack array itself needs no reset.
  always_ff @(posedge clk) begin
    if (reset) stack_q <= stack_d;
  end

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  localparam int unused_stack_depth = STACK_DEPTH;

  always_comb begin
    upc_d = upc_q;
    if (!stall) begin
      case (seq)
        SEQ_JUMP:  upc_d = na;
        SEQ_INC:   upc_d = upc_inc;
        SEQ_DISP1: upc_d = na + disp1_off;
        SEQ_DISP2: upc_d = na + disp2_off;
        SEQ_CBR:   upc_d = cond_true ? na : upc_inc;
        SEQ_CALL:  upc_d = na;
        SEQ_RET:   upc_d = upc_inc;
        SEQ_HOLD:  upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) upc_q <= UADDR_W'(RESET_ADDR);
    else        upc_q <= upc_d;
  end

  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: a queue/array reference model predicts upc, cw and the
// sticky flags after every edge; a monitor process compares them on the falling edge.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        cond_true;
  logic        stall;
  logic        wcs_we;
  logic [4:0]  wcs_addr;
  logic [29:0] wcs_data;
  logic [29:0] cw;
  logic [4:0]  upc;
  logic        stack_ovf;
  logic        stack_unf;

  ucode_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .cond_true (cond_true),
    .stall     (stall),
    .wcs_we    (wcs_we),
    .wcs_addr  (wcs_addr),
    .wcs_data  (wcs_data),
    .cw        (cw),
    .upc       (upc),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          upc;
    logic [29:0] cw;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [29:0] m_store [32];
  int          m_upc = 0;
  int          m_stack[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;
  bit          m_valid = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [29:0] mkWord(input int seq, input int na);
    logic [29:0] w;
    w      = 30'($urandom);
    w[7:5] = seq[2:0];
    w[4:0] = na[4:0];
    return w;
  endfunction

  function automatic logic [29:0] randWord();
    int seq;
    seq = $urandom_range(0, 7);
    if (seq == 7 && $urandom_range(0, 3) != 0) seq = 1;
    return mkWord(seq, $urandom_range(0, 31));
  endfunction

  // Reference: apply the sequencing rules to the inputs held across the edge just taken.
  task automatic modelStep();
    logic [29:0] w;
    int na, seq, inc;
    w   = m_store[m_upc];
    na  = int'(w[4:0]);
    seq = int'(w[7:5]);
    inc = (m_upc + 1) % 32;
    if (wcs_we) m_store[wcs_addr] = wcs_data;
    if (!reset) begin
      m_upc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!stall) begin
      case (seq)
        0: m_upc = na;
        1: m_upc = inc;
        2: m_upc = (na + 2 * int'(op) + int'(funct[5])) % 32;
        3: m_upc = (na + int'(funct[0])) % 32;
        4: m_upc = cond_true ? na : inc;
`ifdef UCODE_STACK_EN
        5: begin
          if (m_stack.size() < 4) m_stack.push_back(inc);
          else m_ovf = 1;
          m_upc = na;
        end
        6: begin
          if (m_stack.size() == 0) begin
            m_unf = 1;
            m_upc = 0;
          end else begin
            m_upc = m_stack.pop_back();
          end
        end
`else
        5: m_upc = na;
        6: m_upc = inc;
`endif
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus();
    exp_t e;
    @(posedge clk);
    #1;
    modelStep();
    if (m_valid) begin
      e.upc = m_upc;
      e.cw  = m_store[m_upc];
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
    end
  endtask

  task automatic loadWord(input int addr, input logic [29:0] data);
    wcs_we   = 1'b1;
    wcs_addr = addr[4:0];
    wcs_data = data;
    applyStimulus();
    wcs_we   = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("mon_upc", 32'(upc), 32'(e.upc));
        checkOutput("mon_cw", 32'(cw), 32'(e.cw));
        checkOutput("mon_ovf", 32'(stack_ovf), 32'(e.ovf));
        checkOutput("mon_unf", 32'(stack_unf), 32'(e.unf));
      end
    end
  end

  initial begin : stimulus
    logic [29:0] w0;
    int          waited;
    reset = 1'b0; stall = 1'b0; op = 2'b10; funct = 6'b100001;
    cond_true = 1'b1; wcs_we = 1'b0; wcs_addr = '0; wcs_data = '0;
    for (int a = 0; a < 32; a++) m_store[a] = '0;

    for (int a = 0; a < 32; a++) loadWord(a, randWord());
    m_valid = 1;

    // Basic sequencing: INC, both dispatches, CBR, stall and wrap.
    w0 = mkWord(1, 0);
    loadWord(0, w0);
    loadWord(1, mkWord(2, 8));
    loadWord(13, mkWord(3, 3));
    loadWord(4, mkWord(1, 0));
    loadWord(5, mkWord(4, 20));
    loadWord(20, mkWord(0, 5));
    loadWord(6, mkWord(1, 0));
    loadWord(7, mkWord(1, 0));
    loadWord(8, mkWord(0, 31));
    loadWord(31, mkWord(1, 0));
    applyStimulus();
    checkOutput("reset_upc", 32'(upc), 32'd0);
    checkOutput("reset_cw", 32'(cw), 32'(w0));
    reset = 1'b1;
    applyStimulus(); checkOutput("inc_0_1", 32'(upc), 32'd1);
    applyStimulus(); checkOutput("dispatch1", 32'(upc), 32'd13);
    applyStimulus(); checkOutput("dispatch2", 32'(upc), 32'd4);
    applyStimulus(); checkOutput("inc_4_5", 32'(upc), 32'd5);
    applyStimulus(); checkOutput("cbr_taken", 32'(upc), 32'd20);
    applyStimulus();
    cond_true = 1'b0;
    applyStimulus(); checkOutput("cbr_not_taken", 32'(upc), 32'd6);
    applyStimulus(); checkOutput("inc_6_7", 32'(upc), 32'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(); checkOutput("stall_hold", 32'(upc), 32'd7);
    end
    stall = 1'b0;
    applyStimulus(); checkOutput("stall_release", 32'(upc), 32'd8);
    applyStimulus(); checkOutput("jump_31", 32'(upc), 32'd31);
    applyStimulus(); checkOutput("inc_wrap", 32'(upc), 32'd0);

    // Nested calls past the stack depth, then returns until underflow.
    reset = 1'b0;
    loadWord(0, mkWord(0, 1));
    loadWord(1, mkWord(5, 2));
    loadWord(2, mkWord(5, 3));
    loadWord(3, mkWord(5, 4));
    loadWord(4, mkWord(5, 5));
    loadWord(5, mkWord(5, 10));
    loadWord(10, mkWord(7, 0));
    reset = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("call_target", 32'(upc), 32'd10);
`ifdef UCODE_STACK_EN
    checkOutput("call_ovf", 32'(stack_ovf), 32'd1);
`else
    checkOutput("nostack_ovf", 32'(stack_ovf), 32'd0);
`endif
    for (int a = 2; a <= 5; a++) loadWord(a, mkWord(6, 0));
    loadWord(10, mkWord(6, 0));
    for (int i = 0; i < 5; i++) applyStimulus();
`ifdef UCODE_STACK_EN
    checkOutput("ret_unf_upc", 32'(upc), 32'd0);
    checkOutput("ret_unf", 32'(stack_unf), 32'd1);
`endif
    applyStimulus();
    stall = 1'b1;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("stall_reset_upc", 32'(upc), 32'd0);
    checkOutput("stall_reset_ovf", 32'(stack_ovf), 32'd0);
    checkOutput("stall_reset_unf", 32'(stack_unf), 32'd0);
    reset = 1'b1;
    stall = 1'b0;

    // Random traffic: program rewrites, stalls, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 40) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      op        = 2'($urandom);
      funct     = 6'($urandom);
      cond_true = 1'($urandom);
      wcs_we    = ($urandom_range(0, 3) == 0);
      wcs_addr  = 5'($urandom);
      wcs_data  = randWord();
      applyStimulus();
    end
    wcs_we = 1'b0;

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
